uart_rx_16x: RTL and testbench

//  UART receiver; counterpart of the UART transmit path. Recovers 8N1 frames from the serial line.

---
 rtl/uart_rx_16x.sv | 122 ++++++++++++
 tb/tb_uart_rx_16x.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_16x.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_16x
// Description : 8N1 UART receiver, oversampled on a baud16 enable tick, with
//               one-clock valid / framing-error pulses and no FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_16x #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 baud16_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] c_cnt_mid  = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] c_cnt_last = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] c_bit_last = BW'(DATA_BITS - 1);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_start = 3'd1;
    localparam logic [2:0] c_st_data  = 3'd2;
    localparam logic [2:0] c_st_stop  = 3'd3;
    localparam logic [2:0] c_st_brk   = 3'd4;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bitn;
    logic [DATA_BITS-1:0] r_shreg;

    assign busy = (r_state != c_st_idle);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rx_meta     <= 1'b1;
            r_rx_s        <= 1'b1;
            r_state       <= c_st_idle;
            r_cnt         <= '0;
            r_bitn        <= '0;
            r_shreg       <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            r_rx_meta     <= rx;
            r_rx_s        <= r_rx_meta;
            rx_valid      <= 1'b0;
            framing_error <= 1'b0;
            if (baud16_tick) begin
                case (r_state)
                    c_st_idle: begin
                        if (!r_rx_s) begin
                            r_state <= c_st_start;
                            r_cnt   <= '0;
                        end
                    end
                    // A start bit that is high again at its midpoint was a glitch.
                    c_st_start: begin
                        if (r_cnt != c_cnt_mid) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (r_rx_s) begin
                            r_state <= c_st_idle;
                        end else begin
                            r_cnt   <= '0;
                            r_bitn  <= '0;
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        if (r_cnt != c_cnt_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
                            r_cnt   <= '0;
                            if (r_bitn == c_bit_last) begin
                                r_state <= c_st_stop;
                            end else begin
                                r_bitn <= r_bitn + 1'b1;
                            end
                        end
                    end
                    // Returning to idle at the stop midpoint lets a back-to-back start edge be caught.
                    c_st_stop: begin
                        if (r_cnt != c_cnt_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else if (r_rx_s) begin
                            rx_data  <= r_shreg;
                            rx_valid <= 1'b1;
                            r_cnt    <= '0;
                            r_state  <= c_st_idle;
                        end else begin
                            framing_error <= 1'b1;
                            r_cnt         <= '0;
                            r_state       <= c_st_brk;
                        end
                    end
                    c_st_brk: begin
                        if (r_rx_s) begin
                            r_state <= c_st_idle;
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_16x.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_16x
// Description : Directed-frame bench for uart_rx_16x with queued expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_16x;

    localparam int TDIV = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       baud16_tick;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       framing_error;
    logic       busy;

    logic       tick_en;
    int         div;
    int         checks = 0;
    int         errors = 0;
    int         busy_clks = 0;
    logic [7:0] last_good;

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t q[$];
    exp_t e_mon;

    uart_rx_16x #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clock         (clock),
        .reset         (reset),
        .baud16_tick   (baud16_tick),
        .rx            (rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    // Tick every TDIV clocks, gated so a stall can be injected.
    initial begin
        baud16_tick = 1'b0;
        div = 0;
        forever begin
            @(negedge clock);
            baud16_tick = tick_en && (div == 0);
            div = (div == TDIV - 1) ? 0 : div + 1;
        end
    end

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (busy) busy_clks++;
        if (!reset && (rx_valid || framing_error)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%h, expected no pulse",
                         rx_valid, framing_error, rx_data);
            end else begin
                e_mon = q.pop_front();
                if (rx_valid !== !e_mon.is_err || framing_error !== e_mon.is_err ||
                    rx_data !== e_mon.data) begin
                    errors++;
                    $display("FAIL pulse: valid=%0b ferr=%0b data=%h, expected valid=%0b ferr=%0b data=%h",
                             rx_valid, framing_error, rx_data, !e_mon.is_err, e_mon.is_err, e_mon.data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            while (baud16_tick !== 1'b1) @(posedge clock);
        end
    endtask

    task automatic send_bit(input logic b, input int n);
        @(negedge clock);
        rx = b;
        wait_ticks(n);
    endtask

    // hook_kind 1: one-clock reset mid data bit (frame abandoned); 2: tick stall mid bit.
    task automatic send_frame(input logic [7:0] d, input logic stopb,
                              input int hook_bit, input int hook_kind);
        send_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) begin
            if (i == hook_bit) begin
                send_bit(d[i], 8);
                @(negedge clock);
                if (hook_kind == 1) begin
                    reset = 1'b1;
                    @(negedge clock);
                    reset = 1'b0;
                    rx = 1'b1;
                    return;
                end
                tick_en = 1'b0;
                repeat (100) @(negedge clock);
                chk("stall_busy", 32'(busy), 32'd1);
                tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                send_bit(d[i], 16);
            end
        end
        send_bit(stopb, 16);
    endtask

    task automatic expect_good(input logic [7:0] d);
        q.push_back('{is_err: 1'b0, data: d});
        last_good = d;
    endtask

    initial begin
        reset = 1'b1;
        rx = 1'b1;
        tick_en = 1'b1;
        last_good = 8'h00;
        repeat (4) @(negedge clock);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_valid", 32'(rx_valid), 32'd0);
        chk("reset_ferr", 32'(framing_error), 32'd0);
        reset = 1'b0;
        wait_ticks(20);

        // 1: single frame 0xA5
        expect_good(8'hA5);
        send_frame(8'hA5, 1'b1, -1, 0);
        chk("a5_busy_after", 32'(busy), 32'd0);
        wait_ticks(16);

        // 2: 0x00 then 0xFF with no idle gap
        expect_good(8'h00);
        send_frame(8'h00, 1'b1, -1, 0);
        expect_good(8'hFF);
        send_frame(8'hFF, 1'b1, -1, 0);
        chk("b2b_busy_after", 32'(busy), 32'd0);
        wait_ticks(16);

        // 3: short low glitch rejected at the start midpoint
        @(negedge clock);
        busy_clks = 0;
        rx = 1'b0;
        wait_ticks(4);
        send_bit(1'b1, 20);
        chk("glitch_busy_clks", 32'(busy_clks), 32'(8 * TDIV));
        chk("glitch_busy_after", 32'(busy), 32'd0);

        // 4: bad stop bit, line held low 40 ticks total
        q.push_back('{is_err: 1'b1, data: last_good});
        send_frame(8'h3C, 1'b0, -1, 0);
        wait_ticks(24);
        chk("break_busy_held", 32'(busy), 32'd1);
        chk("break_rx_data_kept", 32'(rx_data), 32'hFF);
        send_bit(1'b1, 20);
        chk("break_busy_released", 32'(busy), 32'd0);

        // 5: reset during bit 3 of 0x5A, then clean 0x81
        send_frame(8'h5A, 1'b1, 3, 1);
        @(negedge clock);
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_rx_data", 32'(rx_data), 32'h00);
        last_good = 8'h00;
        wait_ticks(32);
        expect_good(8'h81);
        send_frame(8'h81, 1'b1, -1, 0);
        wait_ticks(16);

        // 6: tick stalled for 100 clocks mid-frame
        expect_good(8'hC3);
        send_frame(8'hC3, 1'b1, 3, 2);
        chk("stall_busy_after", 32'(busy), 32'd0);
        wait_ticks(40);

        chk("queue_drained", 32'(q.size()), 32'd0);
        chk("final_rx_data", 32'(rx_data), 32'hC3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
